// File: rtl/tbuf_turn_bus_pkg.sv
// rtl/tbuf_turn_bus_pkg.sv - shared state encodings and counter width for the turnaround bus driver
package tbuf_turn_bus_pkg;

    localparam int TBUF_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_HIZ   = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } tbuf_state_e;

endpackage

// File: rtl/tbuf_pad_drv.sv
// rtl/tbuf_pad_drv.sv - per-bit tristate pad drivers with active-low enable (bufif0 polarity)
module tbuf_pad_drv #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en_n,
    inout  wire  [WIDTH-1:0] pad
);

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            assign pad[g] = en_n ? 1'bz : data[g];
        end
    endgenerate

endmodule

// File: rtl/tbuf_turn_bus.sv
// rtl/tbuf_turn_bus.sv - registered tristate bus driver with enforced high-Z turnaround and bus capture
module tbuf_turn_bus
    import tbuf_turn_bus_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TURN_CYC = 2,
    parameter int REG_OUT  = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] I,
    input  logic             T,
    inout  wire  [WIDTH-1:0] PAD,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic             DRV,
    output logic             BUSY
);

    localparam logic [TBUF_CNT_W-1:0] TURN_LAST =
        (TURN_CYC == 0) ? '0 : TBUF_CNT_W'(TURN_CYC - 1);

    tbuf_state_e           state, state_nxt;
    logic [TBUF_CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0]      drv_data;
    logic                  drive_req;

    // Only a clean 0 requests the bus; X/Z on T must never turn the driver on.
    assign drive_req = (T === 1'b0);

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= ST_HIZ;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_HIZ: begin
                if (drive_req) state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (!drive_req) begin
                    if (TURN_CYC == 0) begin
                        state_nxt = ST_HIZ;
                    end else begin
                        state_nxt = ST_TURN;
                        cnt_nxt   = TURN_LAST;
                    end
                end
            end
            ST_TURN: begin
                if (cnt == '0) state_nxt = ST_HIZ;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = ST_HIZ;
        endcase
    end

    assign DRV  = (state == ST_DRIVE);
    assign BUSY = (state == ST_TURN);

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] data_q;
            always_ff @(posedge CLK) begin
                if (!RSTN)                     data_q <= '0;
                else if (state_nxt == ST_DRIVE) data_q <= I;
            end
            assign drv_data = data_q;
        end else begin : g_comb_out
            assign drv_data = I;
        end
    endgenerate

    // Capture only while the bus was released and not in turnaround.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            Q  <= '0;
            QV <= 1'b0;
        end else if (state == ST_HIZ) begin
            Q  <= PAD;
            QV <= 1'b1;
        end else begin
            QV <= 1'b0;
        end
    end

    tbuf_pad_drv #(
        .WIDTH (WIDTH)
    ) u_pad_drv (
        .data (drv_data),
        .en_n (~DRV),
        .pad  (PAD)
    );

endmodule

// File: tb/tb_tbuf_turn_bus.sv
// tb/tb_tbuf_turn_bus.sv - directed self-checking bench for tbuf_turn_bus
module tb_tbuf_turn_bus;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] i_a, i_b;
    logic       t_a, t_b;
    wire  [7:0] pad_a, pad_b;
    logic [7:0] q_a, q_b;
    logic       qv_a, qv_b, drv_a, drv_b, busy_a, busy_b;
    logic       ext_a_en, ext_b_en;
    logic [7:0] ext_a_val, ext_b_val;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign pad_a = ext_a_en ? ext_a_val : 8'hzz;
    assign pad_b = ext_b_en ? ext_b_val : 8'hzz;

    tbuf_turn_bus #(.WIDTH(8), .TURN_CYC(2), .REG_OUT(1)) dut_a (
        .CLK(clk), .RSTN(rstn), .I(i_a), .T(t_a), .PAD(pad_a),
        .Q(q_a), .QV(qv_a), .DRV(drv_a), .BUSY(busy_a)
    );

    tbuf_turn_bus #(.WIDTH(8), .TURN_CYC(0), .REG_OUT(0)) dut_b (
        .CLK(clk), .RSTN(rstn), .I(i_b), .T(t_b), .PAD(pad_b),
        .Q(q_b), .QV(qv_b), .DRV(drv_b), .BUSY(busy_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; t_a = 1'b0; i_a = 8'hA5; t_b = 1'b1; i_b = 8'h00;
        ext_a_en = 1'b0; ext_a_val = 8'hC3; ext_b_en = 1'b0; ext_b_val = 8'h77;

        // Reset with drive requested: stays released; external value shows unopposed
        step(); step();
        ext_a_en = 1'b1;
        step();
        chk("rst_drv",  {7'b0, drv_a},  8'h00);
        chk("rst_busy", {7'b0, busy_a}, 8'h00);
        chk("rst_q",    q_a,            8'h00);
        chk("rst_qv",   {7'b0, qv_a},   8'h00);
        chk("rst_pad",  pad_a,          8'hC3);

        // Capture while HIZ
        rstn = 1'b1; t_a = 1'b1;
        step();
        chk("cap_q",  q_a,          8'hC3);
        chk("cap_qv", {7'b0, qv_a}, 8'h01);

        // Drive, registered output
        t_a = 1'b0; i_a = 8'h3C;
        step();
        ext_a_en = 1'b0;
        #1;
        chk("drv1_drv", {7'b0, drv_a}, 8'h01);
        chk("drv1_pad", pad_a,         8'h3C);
        chk("drv1_q",   q_a,           8'hC3);
        i_a = 8'h5A;
        #1;
        chk("drv1_pad_hold", pad_a, 8'h3C);
        step();
        chk("drv2_pad", pad_a,          8'h5A);
        chk("drv2_qv",  {7'b0, qv_a},   8'h00);
        chk("drv2_q",   q_a,            8'hC3);

        // Release at edge m, request again from m+1
        t_a = 1'b1;
        step();
        ext_a_en = 1'b1;
        #1;
        chk("turn_m_drv",  {7'b0, drv_a},  8'h00);
        chk("turn_m_busy", {7'b0, busy_a}, 8'h01);
        chk("turn_m_pad",  pad_a,          8'hC3);
        t_a = 1'b0; i_a = 8'h96;
        step();
        chk("turn_m1_busy", {7'b0, busy_a}, 8'h01);
        chk("turn_m1_drv",  {7'b0, drv_a},  8'h00);
        chk("turn_m1_qv",   {7'b0, qv_a},   8'h00);
        step();
        chk("turn_m2_busy", {7'b0, busy_a}, 8'h00);
        chk("turn_m2_drv",  {7'b0, drv_a},  8'h00);
        chk("turn_m2_qv",   {7'b0, qv_a},   8'h00);
        chk("turn_m2_q",    q_a,            8'hC3);
        step();
        ext_a_en = 1'b0;
        #1;
        chk("turn_m3_drv", {7'b0, drv_a}, 8'h01);
        chk("turn_m3_qv",  {7'b0, qv_a},  8'h01);
        chk("turn_m3_pad", pad_a,         8'h96);

        // Reset at the first TURN edge
        t_a = 1'b1;
        step();
        chk("rt_busy_pre", {7'b0, busy_a}, 8'h01);
        rstn = 1'b0;
        step();
        chk("rt_busy", {7'b0, busy_a}, 8'h00);
        chk("rt_drv",  {7'b0, drv_a},  8'h00);
        chk("rt_q",    q_a,            8'h00);
        rstn = 1'b1; t_a = 1'b0; i_a = 8'h11; ext_a_en = 1'b1;
        step();
        ext_a_en = 1'b0;
        #1;
        chk("rt_redrive", {7'b0, drv_a}, 8'h01);
        chk("rt_pad",     pad_a,         8'h11);
        chk("rt_q_cap",   q_a,           8'hC3);

        // No turnaround, combinational output
        t_b = 1'b0; i_b = 8'h12;
        step();
        chk("b_drv",  {7'b0, drv_b}, 8'h01);
        chk("b_pad0", pad_b,         8'h12);
        i_b = 8'h34;
        #1;
        chk("b_pad_comb", pad_b, 8'h34);
        step();
        i_b = 8'hE7;
        #1;
        chk("b_pad_comb2", pad_b, 8'hE7);
        t_b = 1'b1;
        step();
        ext_b_en = 1'b1;
        #1;
        chk("b_rel_drv",  {7'b0, drv_b},  8'h00);
        chk("b_rel_busy", {7'b0, busy_b}, 8'h00);
        chk("b_rel_pad",  pad_b,          8'h77);
        t_b = 1'b0; i_b = 8'h55;
        step();
        ext_b_en = 1'b0;
        #1;
        chk("b_redrive", {7'b0, drv_b},  8'h01);
        chk("b_busy2",   {7'b0, busy_b}, 8'h00);
        chk("b_pad2",    pad_b,          8'h55);
        chk("b_q",       q_b,            8'h77);
        chk("b_qv",      {7'b0, qv_b},   8'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
